core_csr_seq_ctrl: RTL and testbench

CORE_CSR_SEQ_CTRL -- requirements
Module: core_csr_seq_ctrl

---
 rtl/core_csr_seq_ctrl_pkg.sv | 29 ++
 rtl/core_csr_seq_ctrl_rmw_alu.sv | 31 +++
 rtl/core_csr_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_core_csr_seq_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_csr_seq_ctrl_pkg.sv
// Shared CSR sequencer definitions: CSR addresses,
// mstatus bit indices, instruction op bits and FSM states.
package core_csr_seq_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int OP_R    = 0;
    localparam int OP_W    = 1;
    localparam int OP_CS   = 2;
    localparam int OP_ZIMM = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INST_RD,
        ST_INST_WR,
        ST_TRAP_EPC,
        ST_TRAP_CAUSE,
        ST_STAT_RD,
        ST_STAT_WR
    } state_e;

endpackage

// File: rtl/core_csr_seq_ctrl_rmw_alu.sv
// Combinational CSR read-modify-write data path.
// Ports: op/zimm/rs1/rdata in; wr_dat and wr_intent out.
module core_csr_rmw_alu
    import core_csr_seq_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [4:0]      zimm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] wr_dat,
    output logic            wr_intent
);

    logic [XLEN-1:0] operand;

    always_comb begin
        operand = op[OP_ZIMM] ? {{(XLEN-5){1'b0}}, zimm} : rs1;
        // set/clear with a zero operand is a pure read
        wr_intent = op[OP_W] | (op[OP_R] & (operand != '0));
        if (op[OP_W]) begin
            wr_dat = operand;
        end else if (op[OP_CS]) begin
            wr_dat = rdata & ~operand;
        end else begin
            wr_dat = rdata | operand;
        end
    end

endmodule

// File: rtl/core_csr_seq_ctrl.sv
// CSR access / trap entry / mret sequencer FSM.
// Ports: EX inst handshake + resp, trap/mret req/ack/done, CSR bus, busy.
module core_csr_seq_ctrl
    import core_csr_seq_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [CSR_AW-1:0] inst_addr,
    input  logic [3:0]        inst_op,
    input  logic [4:0]        inst_zimm,
    input  logic [XLEN-1:0]   inst_rs1,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_illegal,
    input  logic              trap_req,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic [XLEN-1:0]   trap_cause,
    output logic              trap_ack,
    output logic              trap_done,
    input  logic              mret_req,
    output logic              mret_ack,
    output logic              mret_done,
    output logic [CSR_AW-1:0] csr_addr,
    output logic              csr_rd_en,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic              csr_wr_en,
    output logic [XLEN-1:0]   csr_wr_dat,
    output logic              busy
);

    state_e            state_q;
    logic [CSR_AW-1:0] addr_q;
    logic [3:0]        op_q;
    logic [4:0]        zimm_q;
    logic [XLEN-1:0]   rs1_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   cause_q;
    logic              is_trap_q;
    logic [XLEN-1:0]   alu_dat;
    logic              alu_intent;
    logic              addr_ro;

    function automatic logic [XLEN-1:0] trap_status(
        input logic [XLEN-1:0] s
    );
        logic [XLEN-1:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE] = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mret_status(
        input logic [XLEN-1:0] s
    );
        logic [XLEN-1:0] r;
        r = s;
        r[MSTATUS_MIE] = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

    core_csr_rmw_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .op       (op_q),
        .zimm     (zimm_q),
        .rs1      (rs1_q),
        .rdata    (csr_rdata),
        .wr_dat   (alu_dat),
        .wr_intent(alu_intent)
    );

    assign addr_ro = (addr_q[CSR_AW-1 -: 2] == 2'b11);
    assign busy = (state_q != ST_IDLE);
    assign inst_ready = (state_q == ST_IDLE) & inst_valid &
                        ~trap_req & ~mret_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            op_q      <= '0;
            zimm_q    <= '0;
            rs1_q     <= '0;
            pc_q      <= '0;
            cause_q   <= '0;
            is_trap_q <= 1'b0;
            trap_ack  <= 1'b0;
            mret_ack  <= 1'b0;
        end else begin
            trap_ack <= 1'b0;
            mret_ack <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (trap_req) begin
                        trap_ack  <= 1'b1;
                        pc_q      <= trap_pc;
                        cause_q   <= trap_cause;
                        is_trap_q <= 1'b1;
                        state_q   <= ST_TRAP_EPC;
                    end else if (mret_req) begin
                        mret_ack  <= 1'b1;
                        is_trap_q <= 1'b0;
                        state_q   <= ST_STAT_RD;
                    end else if (inst_valid) begin
                        addr_q  <= inst_addr;
                        op_q    <= inst_op;
                        zimm_q  <= inst_zimm;
                        rs1_q   <= inst_rs1;
                        state_q <= ST_INST_RD;
                    end
                end
                ST_INST_RD:    state_q <= ST_INST_WR;
                ST_INST_WR:    state_q <= ST_IDLE;
                ST_TRAP_EPC:   state_q <= ST_TRAP_CAUSE;
                ST_TRAP_CAUSE: state_q <= ST_STAT_RD;
                ST_STAT_RD:    state_q <= ST_STAT_WR;
                ST_STAT_WR:    state_q <= ST_IDLE;
                default:       state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        csr_addr     = '0;
        csr_rd_en    = 1'b0;
        csr_wr_en    = 1'b0;
        csr_wr_dat   = '0;
        resp_valid   = 1'b0;
        resp_rdata   = '0;
        resp_illegal = 1'b0;
        trap_done    = 1'b0;
        mret_done    = 1'b0;
        unique case (state_q)
            ST_INST_RD: begin
                csr_addr  = addr_q;
                csr_rd_en = 1'b1;
            end
            ST_INST_WR: begin
                csr_addr     = addr_q;
                csr_wr_en    = alu_intent & ~addr_ro;
                csr_wr_dat   = csr_wr_en ? alu_dat : '0;
                resp_valid   = 1'b1;
                resp_rdata   = csr_rdata;
                resp_illegal = alu_intent & addr_ro;
            end
            ST_TRAP_EPC: begin
                csr_addr   = CSR_AW'(CSR_MEPC);
                csr_wr_en  = 1'b1;
                csr_wr_dat = pc_q;
            end
            ST_TRAP_CAUSE: begin
                csr_addr   = CSR_AW'(CSR_MCAUSE);
                csr_wr_en  = 1'b1;
                csr_wr_dat = cause_q;
            end
            ST_STAT_RD: begin
                csr_addr  = CSR_AW'(CSR_MSTATUS);
                csr_rd_en = 1'b1;
            end
            ST_STAT_WR: begin
                csr_addr   = CSR_AW'(CSR_MSTATUS);
                csr_wr_en  = 1'b1;
                csr_wr_dat = is_trap_q ? trap_status(csr_rdata)
                                       : mret_status(csr_rdata);
                trap_done  = is_trap_q;
                mret_done  = ~is_trap_q;
            end
            default: begin
                csr_addr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_core_csr_seq_ctrl.sv
// Scoreboard bench for core_csr_seq_ctrl with a CSR file responder
// and a rule-level reference model of CSR contents.
module tb_core_csr_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [11:0] inst_addr = '0;
    logic [3:0]  inst_op = '0;
    logic [4:0]  inst_zimm = '0;
    logic [31:0] inst_rs1 = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_illegal;
    logic        trap_req = 1'b0;
    logic [31:0] trap_pc = '0;
    logic [31:0] trap_cause = '0;
    logic        trap_ack;
    logic        trap_done;
    logic        mret_req = 1'b0;
    logic        mret_ack;
    logic        mret_done;
    logic [11:0] csr_addr;
    logic        csr_rd_en;
    logic [31:0] csr_rdata = '0;
    logic        csr_wr_en;
    logic [31:0] csr_wr_dat;
    logic        busy;

    always #5 clk = ~clk;

    core_csr_seq_ctrl #(.XLEN(32), .CSR_AW(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_addr(inst_addr), .inst_op(inst_op),
        .inst_zimm(inst_zimm), .inst_rs1(inst_rs1),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_illegal(resp_illegal),
        .trap_req(trap_req), .trap_pc(trap_pc),
        .trap_cause(trap_cause), .trap_ack(trap_ack),
        .trap_done(trap_done), .mret_req(mret_req),
        .mret_ack(mret_ack), .mret_done(mret_done),
        .csr_addr(csr_addr), .csr_rd_en(csr_rd_en),
        .csr_rdata(csr_rdata), .csr_wr_en(csr_wr_en),
        .csr_wr_dat(csr_wr_dat), .busy(busy)
    );

    typedef struct {
        int          kind;
        logic [31:0] rdata;
        logic        illegal;
    } ev_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    ev_t ev_q[$];
    wr_t wr_q[$];
    logic [31:0] mem [4096];
    logic [31:0] ref_csr [4096];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int inst_acc_cyc = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (csr_wr_en) mem[csr_addr] = csr_wr_dat;
        csr_rdata <= csr_rd_en ? mem[csr_addr] : $urandom;
    end

    always @(negedge clk) begin
        ev_t e;
        wr_t w;
        int  kind;
        if (rst_n) begin
            if (csr_wr_en) begin
                check("rd_wr_exclusive", 32'(csr_rd_en), 0);
                if (wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%h data=%h",
                             csr_addr, csr_wr_dat);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", 32'(csr_addr), 32'(w.addr));
                    check("wr_data", csr_wr_dat, w.data);
                end
            end else begin
                check("wr_dat_idle", csr_wr_dat, 0);
            end
            if (resp_valid || trap_done || mret_done) begin
                kind = resp_valid ? 0 : (trap_done ? 1 : 2);
                if (ev_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event kind=%0d", kind);
                end else begin
                    e = ev_q.pop_front();
                    check("event_kind", 32'(kind), 32'(e.kind));
                    if (kind == 0) begin
                        check("resp_rdata", resp_rdata, e.rdata);
                        check("resp_illegal", 32'(resp_illegal),
                              32'(e.illegal));
                        check("resp_latency", 32'(cyc - inst_acc_cyc), 2);
                    end
                end
            end
        end
    end

    task automatic model_inst(logic [11:0] a, logic [3:0] op,
                              logic [4:0] z, logic [31:0] rs1);
        logic [31:0] old;
        logic [31:0] v;
        logic [31:0] nv;
        bit intent;
        bit ro;
        old = ref_csr[a];
        v = op[3] ? {27'b0, z} : rs1;
        intent = op[1] || (op[0] && v != 0);
        ro = (a >= 12'hC00);
        if (op[1]) nv = v;
        else if (op[2]) nv = old & ~v;
        else nv = old | v;
        if (intent && !ro) begin
            ref_csr[a] = nv;
            wr_q.push_back('{a, nv});
        end
        ev_q.push_back('{0, old, intent && ro});
    endtask

    task automatic model_trap(logic [31:0] pc, logic [31:0] cause,
                              bit full);
        logic [31:0] s;
        logic [31:0] mie;
        ref_csr[12'h341] = pc;
        wr_q.push_back('{12'h341, pc});
        ref_csr[12'h342] = cause;
        wr_q.push_back('{12'h342, cause});
        if (full) begin
            s = ref_csr[12'h300];
            mie = (s >> 3) & 1;
            s = (s & ~32'h1888) | (mie << 7) | 32'h1800;
            ref_csr[12'h300] = s;
            wr_q.push_back('{12'h300, s});
            ev_q.push_back('{1, 0, 0});
        end
    endtask

    task automatic model_mret();
        logic [31:0] s;
        logic [31:0] mpie;
        s = ref_csr[12'h300];
        mpie = (s >> 7) & 1;
        s = (s & ~32'h88) | (mpie << 3) | 32'h80;
        ref_csr[12'h300] = s;
        wr_q.push_back('{12'h300, s});
        ev_q.push_back('{2, 0, 0});
    endtask

    task automatic issue(bit t, bit m, bit i, logic [11:0] a,
                         logic [3:0] op, logic [4:0] z,
                         logic [31:0] rs1, logic [31:0] pc,
                         logic [31:0] cause);
        bit dt, dm, di, fin;
        fin = 0;
        if (t) model_trap(pc, cause, 1);
        if (m) model_mret();
        if (i) model_inst(a, op, z, rs1);
        trap_req = t;
        trap_pc = pc;
        trap_cause = cause;
        mret_req = m;
        inst_valid = i;
        inst_addr = a;
        inst_op = op;
        inst_zimm = z;
        inst_rs1 = rs1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            fin = !trap_req && !mret_req && !inst_valid && !busy;
            dt = trap_ack;
            dm = mret_ack;
            di = inst_valid && inst_ready;
            if (di) inst_acc_cyc = cyc;
            @(posedge clk);
            #1;
            if (dt) trap_req = 0;
            if (dm) mret_req = 0;
            if (di) inst_valid = 0;
            if (fin) break;
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout t=%0d m=%0d i=%0d", t, m, i);
            trap_req = 0;
            mret_req = 0;
            inst_valid = 0;
        end
    endtask

    task automatic reset_mid_trap(logic [31:0] pc, logic [31:0] cause);
        bit found;
        found = 0;
        model_trap(pc, cause, 0);
        trap_req = 1;
        trap_pc = pc;
        trap_cause = cause;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (csr_rd_en && csr_addr == 12'h300) begin
                found = 1;
                break;
            end
        end
        check("stat_rd_reached", 32'(found), 1);
        rst_n = 0;
        trap_req = 0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_en", 32'(csr_rd_en), 0);
        check("rst_wr_en", 32'(csr_wr_en), 0);
        check("rst_addr", 32'(csr_addr), 0);
        check("rst_done", 32'(trap_done), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        check("rst_wr_q_empty", 32'(wr_q.size()), 0);
        check("rst_ev_q_empty", 32'(ev_q.size()), 0);
    endtask

    logic [11:0] addr_pool [6];
    logic [3:0]  op_pool [6];

    initial begin
        int rel_cyc;
        bit t, m, i;
        logic [31:0] rs1;
        addr_pool = '{12'h300, 12'h341, 12'h342, 12'hC00, 12'h305,
                      12'h340};
        op_pool = '{4'b0010, 4'b0001, 4'b0101, 4'b1010, 4'b1001,
                    4'b1101};
        for (int k = 0; k < 4096; k++) begin
            mem[k] = $urandom;
            ref_csr[k] = mem[k];
        end
        mem[12'h300] = 32'h1800;
        ref_csr[12'h300] = 32'h1800;
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_rd_en", 32'(csr_rd_en), 0);
        check("reset_wr_en", 32'(csr_wr_en), 0);
        check("reset_resp", 32'(resp_valid), 0);
        check("reset_trap_ack", 32'(trap_ack), 0);
        check("reset_mret_ack", 32'(mret_ack), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        rel_cyc = cyc;
        issue(0, 0, 1, 12'h300, 4'b0001, 5'd0, 32'h8, 0, 0);
        check("first_accept_cycle", 32'(inst_acc_cyc), 32'(rel_cyc));
        issue(0, 0, 1, 12'h300, 4'b0101, 5'd0, 32'h0, 0, 0);
        issue(0, 0, 1, 12'hC00, 4'b0010, 5'd0, 32'h1234, 0, 0);
        mem[12'h300] = 32'h8;
        ref_csr[12'h300] = 32'h8;
        issue(1, 0, 0, 0, 0, 0, 0, 32'h80000010, 32'hB);
        issue(1, 1, 1, 12'h305, 4'b1001, 5'd3, 0, 32'h100, 32'h2);
        reset_mid_trap(32'h200, 32'h7);
        issue(1, 0, 0, 0, 0, 0, 0, 32'h300, 32'h3);
        for (int n = 0; n < 80; n++) begin
            t = ($urandom_range(0, 5) == 0);
            m = ($urandom_range(0, 5) == 0);
            i = ($urandom_range(0, 3) != 0);
            if (!t && !m) i = 1;
            rs1 = ($urandom_range(0, 3) == 0) ? 0 : $urandom;
            issue(t, m, i, addr_pool[$urandom_range(0, 5)],
                  op_pool[$urandom_range(0, 5)], 5'($urandom),
                  rs1, $urandom, $urandom);
        end
        repeat (3) @(negedge clk);
        check("final_ev_q_empty", 32'(ev_q.size()), 0);
        check("final_wr_q_empty", 32'(wr_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
